// File: rtl/dlx_bus_pkg.sv
// Shared definitions for the DLX memory-bus arbiter.
// Contents:
//   arb_state_t    arbiter FSM state encodings (IDLE..ERR)
//   REQ_RD/REQ_WR  requester indices (read/fetch machine, write machine)
//   BUS_TIMEOUT    default number of BUSY cycles allowed without an ack
//   pick_winner    round-robin choice between the two requesters
package dlx_bus_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_GRANT = 3'd1,
    ARB_BUSY  = 3'd2,
    ARB_DONE  = 3'd3,
    ARB_ERR   = 3'd4
  } arb_state_t;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  localparam int BUS_TIMEOUT = 16;

  // On a tie the requester that did not own the bus last time wins.
  // Only meaningful when at least one request is active.
  function automatic logic pick_winner(input logic req_rd, input logic req_wr,
                                       input logic last_owner);
    if (req_rd && req_wr) begin
      return ~last_owner;
    end else if (req_wr) begin
      return REQ_WR;
    end else begin
      return REQ_RD;
    end
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two bus machines, the memory bus and the arbiter.
// Modports:
//   master  arbiter side: takes requests/strobes and the memory ack, drives
//           grants, routed acks, memory strobes, bus_err, owner, arb_state
//   slave   environment side: drives requests/strobes and the memory ack
// Signals (all active-low where suffixed _n):
//   req0/as0_n/wr0_n/gnt0/ack0_n   requester 0 (read/fetch machine)
//   req1/as1_n/wr1_n/gnt1/ack1_n   requester 1 (write machine)
//   as_n/wr_n/ack_n                shared memory bus
//   bus_err, owner, arb_state      status
interface mem_bus_arbiter_if;

  logic       req0;
  logic       as0_n;
  logic       wr0_n;
  logic       gnt0;
  logic       ack0_n;
  logic       req1;
  logic       as1_n;
  logic       wr1_n;
  logic       gnt1;
  logic       ack1_n;
  logic       as_n;
  logic       wr_n;
  logic       ack_n;
  logic       bus_err;
  logic       owner;
  logic [2:0] arb_state;

  modport master (
    input  req0, as0_n, wr0_n, req1, as1_n, wr1_n, ack_n,
    output gnt0, ack0_n, gnt1, ack1_n, as_n, wr_n, bus_err, owner, arb_state
  );

  modport slave (
    output req0, as0_n, wr0_n, req1, as1_n, wr1_n, ack_n,
    input  gnt0, ack0_n, gnt1, ack1_n, as_n, wr_n, bus_err, owner, arb_state
  );

endinterface

// File: rtl/bus_watchdog.sv
// Loadable watchdog timer for the arbiter's BUSY phase.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset (count -> 0)
//   clr_i      load the count with zero (has priority over en_i)
//   en_i       advance the count by one
//   expired_o  count has reached TIMEOUT-1, i.e. the last allowed wait cycle
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one asynchronous memory bus (as_n/wr_n/ack_n)
// between the read/fetch machine (requester 0) and the write machine
// (requester 1). A grant covers a whole transaction; a watchdog aborts a
// transaction that never sees an ack.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    mem_bus_arbiter_if.master: requests, strobes, grants, routed acks,
//          memory bus strobes/ack, bus_err pulse, owner, arb_state
module mem_bus_arbiter
  import dlx_bus_pkg::*;
#(
  parameter int TIMEOUT = BUS_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       owner_q;
  logic       owner_d;
  logic [1:0] gnt_q;
  logic [1:0] gnt_d;
  logic       bus_err_q;
  logic       bus_err_d;

  logic       timer_clr;
  logic       timer_en;
  logic       timer_expired;

  logic       own_req;
  logic       own_as_n;
  logic       own_wr_n;
  logic       drive_bus;
  logic       ack_phase;
  logic [1:0] ack_route_n;

  // Only the owner's signals ever reach the FSM or the bus.
  assign own_req  = (owner_q == REQ_WR) ? bus.req1  : bus.req0;
  assign own_as_n = (owner_q == REQ_WR) ? bus.as1_n : bus.as0_n;
  assign own_wr_n = (owner_q == REQ_WR) ? bus.wr1_n : bus.wr0_n;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (reset),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    bus_err_d = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ARB_GRANT;
          owner_d = pick_winner(bus.req0, bus.req1, owner_q);
        end
      end
      ARB_GRANT: begin
        if (!own_as_n) begin
          state_d   = ARB_BUSY;
          timer_clr = 1'b1;
        end else if (!own_req) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // An ack in the last allowed cycle still completes normally.
        if (!bus.ack_n) begin
          state_d = ARB_DONE;
        end else if (timer_expired) begin
          state_d   = ARB_ERR;
          bus_err_d = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      ARB_DONE: begin
        if (own_as_n) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ERR: begin
        // Grant is held until the aborted machine gives up its request.
        if (!own_req) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Grants are registered from the next state so they switch together with
  // the FSM and can never overlap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt_d[gi] = (state_d != ARB_IDLE) && (owner_d == 1'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= REQ_WR;
      gnt_q     <= 2'b00;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign drive_bus = (state_q == ARB_GRANT) || (state_q == ARB_BUSY) ||
                     (state_q == ARB_DONE);
  assign ack_phase = (state_q == ARB_BUSY) || (state_q == ARB_DONE);

  // A stray ack outside BUSY/DONE, or toward the non-owner, is swallowed.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ack
    assign ack_route_n[gi] = !(ack_phase && (owner_q == 1'(gi)) && !bus.ack_n);
  end

  assign bus.as_n      = drive_bus ? own_as_n : 1'b1;
  assign bus.wr_n      = drive_bus ? own_wr_n : 1'b1;
  assign bus.ack0_n    = ack_route_n[0];
  assign bus.ack1_n    = ack_route_n[1];
  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.bus_err   = bus_err_q;
  assign bus.owner     = owner_q;
  assign bus.arb_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed transactions with literal
// expectations, then randomized stimulus, with a transaction-level model
// checked against every output on every falling clock edge.
module tb_mem_bus_arbiter;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 granted, 2 waiting for ack, 3 acked, 4 aborted.
  int m_state = 0;
  bit m_owner = 1'b1;
  int m_busy_cycles = 0;
  bit m_err = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    int ns;
    int nb;
    bit no;
    bit ne;
    bit oreq;
    bit oas;
    if (reset) begin
      m_state       <= 0;
      m_owner       <= 1'b1;
      m_busy_cycles <= 0;
      m_err         <= 1'b0;
    end else begin
      ns   = m_state;
      no   = m_owner;
      nb   = m_busy_cycles;
      ne   = 1'b0;
      oreq = m_owner ? bus_if.req1 : bus_if.req0;
      oas  = m_owner ? bus_if.as1_n : bus_if.as0_n;
      if (m_state == 0) begin
        if (bus_if.req0 || bus_if.req1) begin
          no = (bus_if.req0 && bus_if.req1) ? !m_owner : bus_if.req1;
          ns = 1;
        end
      end else if (m_state == 1) begin
        if (!oas) begin
          ns = 2;
          nb = 1;
        end else if (!oreq) begin
          ns = 0;
        end
      end else if (m_state == 2) begin
        if (!bus_if.ack_n) begin
          ns = 3;
        end else if (m_busy_cycles == TMO) begin
          ns = 4;
          ne = 1'b1;
        end else begin
          nb = m_busy_cycles + 1;
        end
      end else if (m_state == 3) begin
        if (oas) ns = 0;
      end else begin
        if (!oreq) ns = 0;
      end
      if (ns == 0 && m_state != 0) begin
        $display("txn owner=%0d ended from phase %0d at %0t", m_owner, m_state, $time);
      end
      m_state       <= ns;
      m_owner       <= no;
      m_busy_cycles <= nb;
      m_err         <= ne;
    end
  end

  // Compare process: mid-cycle, with inputs and state both settled.
  always @(negedge clk) begin : compare
    bit drv;
    bit ackp;
    bit e_as;
    bit e_wr;
    bit e_ack0;
    bit e_ack1;
    drv    = (m_state >= 1 && m_state <= 3);
    ackp   = (m_state == 2 || m_state == 3);
    e_as   = drv ? (m_owner ? bus_if.as1_n : bus_if.as0_n) : 1'b1;
    e_wr   = drv ? (m_owner ? bus_if.wr1_n : bus_if.wr0_n) : 1'b1;
    e_ack0 = (ackp && !m_owner) ? bus_if.ack_n : 1'b1;
    e_ack1 = (ackp && m_owner) ? bus_if.ack_n : 1'b1;
    chk("gnt0", bus_if.gnt0, (m_state != 0 && !m_owner));
    chk("gnt1", bus_if.gnt1, (m_state != 0 && m_owner));
    chk("as_n", bus_if.as_n, e_as);
    chk("wr_n", bus_if.wr_n, e_wr);
    chk("ack0_n", bus_if.ack0_n, e_ack0);
    chk("ack1_n", bus_if.ack1_n, e_ack1);
    chk("bus_err", bus_if.bus_err, m_err);
    chk("owner", bus_if.owner, m_owner);
    chk("arb_state", bus_if.arb_state, 8'(m_state));
  end

  task automatic drive(input logic r0, input logic a0, input logic w0,
                       input logic r1, input logic a1, input logic w1, input logic ak);
    bus_if.req0  = r0;
    bus_if.as0_n = a0;
    bus_if.wr0_n = w0;
    bus_if.req1  = r1;
    bus_if.as1_n = a1;
    bus_if.wr1_n = w1;
    bus_if.ack_n = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    bit win [3];
    int busy_cnt;
    int err_cnt;
    drive(0, 1, 1, 0, 1, 1, 1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bus_if.arb_state, 0);
    chk("rst_gnt0", bus_if.gnt0, 0);
    chk("rst_gnt1", bus_if.gnt1, 0);
    chk("rst_bus_err", bus_if.bus_err, 0);
    chk("rst_owner", bus_if.owner, 1);
    chk("rst_as_n", bus_if.as_n, 1);
    chk("rst_ack0_n", bus_if.ack0_n, 1);
    reset = 1'b0;
    tick();

    // Single read transaction from requester 0.
    drive(1, 1, 1, 0, 1, 1, 1);
    tick();
    chk("A_gnt0", bus_if.gnt0, 1);
    chk("A_state", bus_if.arb_state, 1);
    drive(1, 0, 1, 0, 1, 1, 1);
    tick();
    tick();
    tick();
    drive(1, 0, 1, 0, 1, 1, 0);
    #1;
    chk("A_ack0_n", bus_if.ack0_n, 0);
    chk("A_ack1_n", bus_if.ack1_n, 1);
    tick();
    chk("A_done", bus_if.arb_state, 3);
    drive(0, 1, 1, 0, 1, 1, 1);
    tick();
    chk("A_idle", bus_if.arb_state, 0);
    chk("A_gnt0_drop", bus_if.gnt0, 0);
    $display("txn A: read by requester 0 with ack");

    // Asynchronous reset while requester 1 is mid-BUSY.
    drive(0, 1, 1, 1, 1, 1, 1);
    tick();
    drive(0, 1, 1, 1, 0, 0, 1);
    tick();
    chk("R_busy", bus_if.arb_state, 2);
    #1 reset = 1'b1;
    #1;
    chk("R_as_n", bus_if.as_n, 1);
    chk("R_gnt0", bus_if.gnt0, 0);
    chk("R_gnt1", bus_if.gnt1, 0);
    chk("R_state", bus_if.arb_state, 0);
    chk("R_owner", bus_if.owner, 1);
    drive(0, 1, 1, 0, 1, 1, 1);
    tick();
    reset = 1'b0;
    $display("txn R: reset during BUSY of requester 1");

    // Both requesting continuously: owners must alternate 0,1,0.
    drive(1, 1, 1, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 4 && !(bus_if.gnt0 || bus_if.gnt1); w++) tick();
      chk("B_gnt_seen", (bus_if.gnt0 || bus_if.gnt1), 1);
      chk("B_excl", (bus_if.gnt0 && bus_if.gnt1), 0);
      win[k] = bus_if.gnt1;
      drive(1, 0, 1, 1, 0, 0, 1);
      tick();
      drive(1, 0, 1, 1, 0, 0, 0);
      #1;
      chk("B_wr_n", bus_if.wr_n, win[k] ? 0 : 1);
      tick();
      drive(1, 1, 1, 1, 1, 1, 1);
      tick();
      $display("txn B%0d: tie won by requester %0d", k, win[k]);
    end
    chk("B_order0", 8'(win[0]), 0);
    chk("B_order1", 8'(win[1]), 1);
    chk("B_order2", 8'(win[2]), 0);
    drive(0, 1, 1, 0, 1, 1, 1);
    tick();

    // Watchdog: no ack ever from the memory.
    drive(0, 1, 1, 1, 1, 1, 1);
    tick();
    drive(0, 1, 1, 1, 0, 1, 1);
    busy_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus_if.arb_state == 3'd2) busy_cnt++;
      if (bus_if.bus_err) begin
        err_cnt++;
        chk("C_as_n_err", bus_if.as_n, 1);
      end
    end
    chk("C_busy_cycles", 8'(busy_cnt), 16);
    chk("C_err_pulses", 8'(err_cnt), 1);
    chk("C_err_state", bus_if.arb_state, 4);
    chk("C_gnt1_held", bus_if.gnt1, 1);
    drive(0, 1, 1, 0, 1, 1, 1);
    tick();
    chk("C_idle", bus_if.arb_state, 0);
    $display("txn C: requester 1 aborted by watchdog");

    // Ack arriving exactly in the 16th BUSY cycle.
    drive(1, 1, 1, 0, 1, 1, 1);
    tick();
    drive(1, 0, 1, 0, 1, 1, 1);
    tick();
    repeat (15) tick();
    chk("D_busy16", bus_if.arb_state, 2);
    drive(1, 0, 1, 0, 1, 1, 0);
    tick();
    chk("D_done", bus_if.arb_state, 3);
    chk("D_no_err", bus_if.bus_err, 0);
    drive(0, 1, 1, 0, 1, 1, 1);
    tick();
    chk("D_idle", bus_if.arb_state, 0);
    $display("txn D: ack in last allowed cycle");

    // Requester 1 abandons before strobing; pending requester 0 follows.
    drive(0, 1, 1, 1, 1, 1, 1);
    tick();
    chk("E_gnt1", bus_if.gnt1, 1);
    drive(1, 1, 1, 0, 1, 1, 1);
    tick();
    chk("E_idle", bus_if.arb_state, 0);
    chk("E_gnt1_drop", bus_if.gnt1, 0);
    tick();
    chk("E_gnt0", bus_if.gnt0, 1);
    drive(0, 1, 1, 0, 1, 1, 1);
    tick();
    tick();
    $display("txn E: abandoned grant, then requester 0");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
